// File: rtl/mxint8_bd_pkg.sv
// Shared types and FP32/E8M0 field constants for the MXINT8 block sequencer.
package mxint8_bd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DRAIN = 2'd3
  } bd_state_e;

  localparam int         EXP_MSB        = 30;
  localparam int         EXP_LSB        = 23;
  localparam logic [7:0] EXP_ALL1       = 8'hFF;
  localparam logic [7:0] E8M0_NAN       = 8'hFF;
  localparam int         DEF_BLOCK_SIZE = 32;

  // Biased exponent field; sign is deliberately excluded.
  function automatic logic [7:0] fp32_exp(input logic [31:0] v);
    return v[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/mxint8_bd_ctrl_if.sv
// Upstream element stream and quantizer-side stream of the block sequencer.
interface mxint8_bd_ctrl_if #(
  parameter int FP32_WIDTH  = 32,
  parameter int SCALE_WIDTH = 8,
  parameter int IDX_W       = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [FP32_WIDTH-1:0]  in_fp32;
  logic                   q_valid;
  logic                   q_ready;
  logic [FP32_WIDTH-1:0]  q_fp32;
  logic [SCALE_WIDTH-1:0] q_scale;
  logic [IDX_W-1:0]       q_idx;
  logic                   q_first;
  logic                   q_last;
  logic                   busy;
  logic                   nan_block;

  modport master (
    output in_valid, in_fp32, q_ready,
    input  in_ready, q_valid, q_fp32, q_scale, q_idx, q_first, q_last, busy, nan_block
  );

  modport slave (
    input  in_valid, in_fp32, q_ready,
    output in_ready, q_valid, q_fp32, q_scale, q_idx, q_first, q_last, busy, nan_block
  );
endinterface

// File: rtl/mxint8_bd_buf.sv
// One-block element store: single write port, asynchronous read port.
module mxint8_bd_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents need no reset since every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/mxint8_bd_ctrl.sv
// MXINT8 block sequencer: buffers a block, derives its shared E8M0 scale,
// then replays the block with the final scale attached to every element.
module mxint8_bd_ctrl
  import mxint8_bd_pkg::*;
#(
  parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int FP32_WIDTH  = 32,
  parameter int SCALE_WIDTH = 8,
  parameter int IDX_W       = $clog2(BLOCK_SIZE)
) (
  input logic             clk,
  input logic             rst,
  mxint8_bd_ctrl_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  bd_state_e              state_r;
  bd_state_e              state_nxt_s;
  logic [IDX_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       rd_ptr_r;
  logic [SCALE_WIDTH-1:0] max_exp_r;
  logic [SCALE_WIDTH-1:0] scale_r;
  logic [SCALE_WIDTH-1:0] in_exp_s;
  logic                   nan_acc_r;
  logic                   nan_block_r;
  logic                   accept_s;
  logic                   drain_s;
  logic                   in_hs_s;
  logic                   q_hs_s;
  logic                   in_nan_s;
  logic [FP32_WIDTH-1:0]  rd_data_s;

  assign in_exp_s = fp32_exp(bus.in_fp32);
  assign in_nan_s = (in_exp_s == EXP_ALL1);
  assign accept_s = (state_r == ST_IDLE) || (state_r == ST_FILL);
  assign drain_s  = (state_r == ST_DRAIN);
  assign in_hs_s  = bus.in_valid && accept_s;
  assign q_hs_s   = bus.q_ready && drain_s;

  mxint8_bd_buf #(
    .DEPTH (BLOCK_SIZE),
    .WIDTH (FP32_WIDTH),
    .AW    (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (in_hs_s),
    .waddr (cnt_r),
    .wdata (bus.in_fp32),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) state_nxt_s = ST_FILL;
        else         state_nxt_s = ST_IDLE;
      end
      ST_FILL: begin
        if (in_hs_s && (cnt_r == LAST_IDX)) state_nxt_s = ST_SCALE;
        else                                state_nxt_s = ST_FILL;
      end
      ST_SCALE: state_nxt_s = ST_DRAIN;
      ST_DRAIN: begin
        if (q_hs_s && (rd_ptr_r == LAST_IDX)) state_nxt_s = ST_IDLE;
        else                                  state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Fill/drain pointers, running max exponent, NaN accumulation and the latched block scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= '0;
      rd_ptr_r    <= '0;
      max_exp_r   <= '0;
      nan_acc_r   <= 1'b0;
      scale_r     <= '0;
      nan_block_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_hs_s) begin
            cnt_r       <= IDX_W'(1);
            max_exp_r   <= in_exp_s;
            nan_acc_r   <= in_nan_s;
            nan_block_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (in_hs_s) begin
            // Pointer returns to 0 on the last slot so it never leaves 0..BLOCK_SIZE-1.
            cnt_r     <= (cnt_r == LAST_IDX) ? '0 : cnt_r + IDX_W'(1);
            max_exp_r <= (in_exp_s > max_exp_r) ? in_exp_s : max_exp_r;
            nan_acc_r <= nan_acc_r | in_nan_s;
          end
        end
        ST_SCALE: begin
          scale_r     <= nan_acc_r ? E8M0_NAN : max_exp_r;
          nan_block_r <= nan_acc_r;
          rd_ptr_r    <= '0;
        end
        ST_DRAIN: begin
          if (q_hs_s) begin
            if (rd_ptr_r == LAST_IDX) begin
              rd_ptr_r  <= '0;
              max_exp_r <= '0;
              nan_acc_r <= 1'b0;
            end else begin
              rd_ptr_r <= rd_ptr_r + IDX_W'(1);
            end
          end
        end
        default: begin
          cnt_r    <= '0;
          rd_ptr_r <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = accept_s;
  assign bus.q_valid   = drain_s;
  assign bus.q_fp32    = drain_s ? rd_data_s : '0;
  assign bus.q_scale   = scale_r;
  assign bus.q_idx     = drain_s ? rd_ptr_r : '0;
  assign bus.q_first   = drain_s && (rd_ptr_r == '0);
  assign bus.q_last    = drain_s && (rd_ptr_r == LAST_IDX);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.nan_block = nan_block_r;

endmodule
